iir_biquad_selftrigger: RTL and testbench

//  Parametrised second-order (biquad) IIR filter with runtime-loadable coefficients, output saturation and a

---
 rtl/iir_biquad_selftrigger_if.sv | 31 +++
 rtl/iir_biquad_selftrigger.sv | 239 +++++++++++++++++++++++
 tb/tb_iir_biquad_selftrigger.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_biquad_selftrigger_if.sv
// Per-channel bus between the ADC sample stream / slow control and the
// biquad self-trigger block. The block is the slave; the stream source and
// trigger/readout side together act as master.
interface iir_biquad_selftrigger_if #(
  parameter int W  = 16,
  parameter int CW = 18
);
  logic                 clear;
  logic                 in_valid;
  logic signed [W-1:0]  x_in;
  logic                 bypass;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic signed [W-1:0]  thresh;
  logic                 out_valid;
  logic signed [W-1:0]  y_out;
  logic                 trigger;
  logic                 sat_flag;
  logic [15:0]          trig_count;

  modport master (
    output clear, in_valid, x_in, bypass, coef_we, coef_addr, coef_wdata, thresh,
    input  out_valid, y_out, trigger, sat_flag, trig_count
  );

  modport slave (
    input  clear, in_valid, x_in, bypass, coef_we, coef_addr, coef_wdata, thresh,
    output out_valid, y_out, trigger, sat_flag, trig_count
  );
endinterface

// File: rtl/iir_biquad_selftrigger.sv
// Second-order IIR (biquad) with loadable Q3.(CW-3) coefficients, guarded
// internal state, saturating/rounded output and a threshold + zero-crossover
// self-trigger with a bounded crossover window and post-trigger holdoff.
module iir_biquad_selftrigger #(
  parameter int W       = 16,
  parameter int CW      = 18,
  parameter int G       = 9,
  parameter int WIN_W   = 8,
  parameter int HOLDOFF = 64,
  parameter logic [CW-1:0] B0_INIT = CW'(32'h0007C8F),
  parameter logic [CW-1:0] B1_INIT = CW'(32'h0003C5BC),
  parameter logic [CW-1:0] B2_INIT = CW'(32'h0007B0A),
  parameter logic [CW-1:0] A1_INIT = CW'(32'h000E810),
  parameter logic [CW-1:0] A2_INIT = CW'(32'h0003A590)
) (
  input logic                     clk,
  input logic                     reset_n,
  iir_biquad_selftrigger_if.slave bus
);

  // State carries G guard bits below the sample LSB; the accumulator is wide
  // enough that the five-term sum can never wrap.
  localparam int SW   = W + G;
  localparam int AW   = SW + CW + 3;
  localparam int FRAC = CW - 3;
  localparam int HCW  = $clog2(HOLDOFF + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Coefficient set; a1/a2 are stored with the feedback sign already applied.
  logic signed [CW-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;

  // Filter history.
  logic signed [SW-1:0] r_x1, r_x2, r_y1, r_y2;

  // Output side.
  logic signed [W-1:0]  r_y_out;
  logic signed [W-1:0]  r_y_prev;
  logic                 r_out_valid;
  logic                 r_trigger;
  logic                 r_sat;
  logic [15:0]          r_trig_count;

  // Trigger FSM.
  logic [1:0]           r_state;
  logic [WIN_W-1:0]     r_win;
  logic [HCW-1:0]       r_hold;

  // Datapath wires.
  logic signed [SW-1:0] w_x0;
  logic signed [AW-1:0] w_p0, w_p1, w_p2, w_p3, w_p4;
  logic signed [AW-1:0] w_acc;
  logic signed [AW-1:0] w_shift;
  logic                 w_s_ovf;
  logic signed [SW-1:0] w_s;
  logic [SW:0]          w_round;
  logic                 w_y_ovf;
  logic signed [W-1:0]  w_y_filt;
  logic signed [W-1:0]  w_y_new;
  logic                 w_sat_evt;

  // FSM wires.
  logic                 w_below;
  logic                 w_cross;
  logic [WIN_W-1:0]     w_win_inc;
  logic [HCW-1:0]       w_hold_inc;
  logic [1:0]           w_state_nxt;
  logic [WIN_W-1:0]     w_win_nxt;
  logic [HCW-1:0]       w_hold_nxt;
  logic                 w_trig_nxt;

  // Input sample aligned to the state scale (guard bits zero).
  assign w_x0 = {bus.x_in, {G{1'b0}}};

  // Products are formed at full accumulator width so the sum cannot overflow.
  assign w_p0 = AW'(r_b0) * AW'(w_x0);
  assign w_p1 = AW'(r_b1) * AW'(r_x1);
  assign w_p2 = AW'(r_b2) * AW'(r_x2);
  assign w_p3 = AW'(r_a1) * AW'(r_y1);
  assign w_p4 = AW'(r_a2) * AW'(r_y2);
  assign w_acc = w_p0 + w_p1 + w_p2 + w_p3 + w_p4;

  // Drop the coefficient fraction and clamp to the state width.
  assign w_shift = w_acc >>> FRAC;
  assign w_s_ovf = (w_shift[AW-1:SW-1] != {(AW-SW+1){w_shift[AW-1]}});
  assign w_s     = w_s_ovf ? {w_shift[AW-1], {(SW-1){~w_shift[AW-1]}}} : w_shift[SW-1:0];

  // Round half up by adding half an output LSB before discarding the guard bits,
  // then clamp the one extra integer bit back to W.
  assign w_round  = {w_s[SW-1], w_s} + {{(SW+1-G){1'b0}}, 1'b1, {(G-1){1'b0}}};
  assign w_y_ovf  = (w_round[SW] != w_round[SW-1]);
  assign w_y_filt = w_y_ovf ? {w_round[SW], {(W-1){~w_round[SW]}}} : w_round[SW-1:G];

  assign w_y_new   = bus.bypass ? bus.x_in : w_y_filt;
  assign w_sat_evt = !bus.bypass && (w_s_ovf || w_y_ovf);

  // Trigger conditions are judged on the sample about to be presented.
  assign w_below    = (w_y_new < bus.thresh);
  assign w_cross    = r_y_prev[W-1] && !w_y_new[W-1];
  assign w_win_inc  = r_win + WIN_W'(1);
  assign w_hold_inc = r_hold + HCW'(1);

  // Next-state logic of the self-trigger; a crossover beats window expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_hold_nxt  = r_hold;
    w_trig_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_below) begin
          w_state_nxt = ST_ARMED;
          w_win_nxt   = '0;
        end
      end
      ST_ARMED: begin
        w_win_nxt = w_win_inc;
        if (w_cross) begin
          w_trig_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
        end else if (w_win_inc[WIN_W-1]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_hold_nxt = w_hold_inc;
        if (w_hold_inc == HCW'(HOLDOFF)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Coefficient registers; writes land on the edge, so a sample taken in the
  // same cycle still sees the old set. Clear leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b0 <= B0_INIT;
      r_b1 <= B1_INIT;
      r_b2 <= B2_INIT;
      r_a1 <= A1_INIT;
      r_a2 <= A2_INIT;
    end else if (bus.coef_we) begin
      case (bus.coef_addr)
        3'd0:    r_b0 <= bus.coef_wdata;
        3'd1:    r_b1 <= bus.coef_wdata;
        3'd2:    r_b2 <= bus.coef_wdata;
        3'd3:    r_a1 <= bus.coef_wdata;
        3'd4:    r_a2 <= bus.coef_wdata;
        default: ;
      endcase
    end
  end

  // Filter history shifts only on filtered samples; bypass freezes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
    end else if (bus.clear) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
    end else if (bus.in_valid && !bus.bypass) begin
      r_x1 <= w_x0;
      r_x2 <= r_x1;
      r_y1 <= w_s;
      r_y2 <= r_y1;
    end
  end

  // Output sample, its strobe and the sticky saturation flag; clear drops the
  // strobe but leaves the last presented sample visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y_out     <= '0;
      r_y_prev    <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else if (bus.clear) begin
      r_y_prev    <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_y_out  <= w_y_new;
        r_y_prev <= w_y_new;
        if (w_sat_evt) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  // Trigger FSM advances once per presented sample; the trigger pulse lines
  // up with the out_valid of the crossing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_win        <= '0;
      r_hold       <= '0;
      r_trigger    <= 1'b0;
      r_trig_count <= '0;
    end else if (bus.clear) begin
      r_state      <= ST_IDLE;
      r_win        <= '0;
      r_hold       <= '0;
      r_trigger    <= 1'b0;
      r_trig_count <= '0;
    end else begin
      r_trigger <= bus.in_valid && w_trig_nxt;
      if (bus.in_valid) begin
        r_state <= w_state_nxt;
        r_win   <= w_win_nxt;
        r_hold  <= w_hold_nxt;
        if (w_trig_nxt) begin
          r_trig_count <= r_trig_count + 16'd1;
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.y_out      = r_y_out;
  assign bus.trigger    = r_trigger;
  assign bus.sat_flag   = r_sat;
  assign bus.trig_count = r_trig_count;

endmodule

// File: tb/tb_iir_biquad_selftrigger.sv
// Directed bench for the biquad self-trigger: hand-computed expected samples
// for default HPK coefficients, identity/feedback sets, saturation, rounding,
// coefficient timing, window and holdoff boundaries, bypass and async reset.
module tb_iir_biquad_selftrigger;

  localparam logic [17:0] ONE      = 18'h08000;
  localparam logic [17:0] HALF     = 18'h04000;
  localparam logic [17:0] NEG_HALF = 18'h3C000;
  localparam logic [17:0] BIG      = 18'h1FFFF;

  logic clk = 1'b0;
  logic reset_n;

  int assertCount = 0;
  int failCount   = 0;

  iir_biquad_selftrigger_if #(.W(16), .CW(18)) bus ();

  iir_biquad_selftrigger dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Advance to the next falling edge and drop all one-cycle strobes.
  task automatic tick();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.coef_we  = 1'b0;
  endtask

  // Present one sample; outputs for it are visible on return.
  task automatic applyStimulus(input logic signed [15:0] x);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    tick();
  endtask

  // Write one coefficient register (no sample in that cycle unless set by caller).
  task automatic writeCoef(input logic [2:0] addr, input logic [17:0] data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr;
    bus.coef_wdata = data;
    tick();
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.clear      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.x_in       = '0;
    bus.bypass     = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.thresh     = -16'sd10;

    // Reset state.
    #23;
    checkOutput("rst y_out", bus.y_out, 0);
    checkOutput("rst out_valid", bus.out_valid, 0);
    checkOutput("rst trigger", bus.trigger, 0);
    checkOutput("rst sat_flag", bus.sat_flag, 0);
    checkOutput("rst trig_count", bus.trig_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // HPK defaults, step of 1000, clear mid-stream.
    applyStimulus(16'sd1000);
    checkOutput("hpk s1 valid", bus.out_valid, 1);
    checkOutput("hpk s1 y", bus.y_out, 973);
    applyStimulus(16'sd1000);
    checkOutput("hpk s2 y", bus.y_out, 2282);
    bus.clear = 1'b1;
    applyStimulus(16'sd1000);
    checkOutput("clear valid", bus.out_valid, 0);
    checkOutput("clear y hold", bus.y_out, 2282);
    applyStimulus(16'sd1000);
    checkOutput("hpk after clear y", bus.y_out, 973);

    // Identity coefficients; last write issued together with clear.
    writeCoef(3'd0, ONE);
    writeCoef(3'd1, '0);
    writeCoef(3'd2, '0);
    writeCoef(3'd3, '0);
    bus.clear = 1'b1;
    writeCoef(3'd4, '0);
    applyStimulus(16'sd1234);
    checkOutput("id 1234 valid", bus.out_valid, 1);
    checkOutput("id 1234", bus.y_out, 1234);
    applyStimulus(-16'sd5);
    checkOutput("id -5 valid", bus.out_valid, 1);
    checkOutput("id -5", bus.y_out, -5);
    applyStimulus(16'sd32767);
    checkOutput("id 32767", bus.y_out, 32767);
    tick();
    checkOutput("valid pulse", bus.out_valid, 0);
    checkOutput("no sat at fullscale", bus.sat_flag, 0);

    // Saturation with b0 just below 4.
    writeCoef(3'd0, BIG);
    applyStimulus(16'sd16000);
    checkOutput("sat pos y", bus.y_out, 32767);
    checkOutput("sat flag set", bus.sat_flag, 1);
    applyStimulus(-16'sd16000);
    checkOutput("sat neg y", bus.y_out, -32768);
    bus.clear = 1'b1;
    tick();
    checkOutput("sat flag cleared", bus.sat_flag, 0);

    // Coefficient write in the same cycle as a sample, rounding, ignored address.
    writeCoef(3'd0, ONE);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'd0;
    bus.coef_wdata = HALF;
    applyStimulus(16'sd1000);
    checkOutput("old b0 used", bus.y_out, 1000);
    applyStimulus(16'sd3);
    checkOutput("round +1.5", bus.y_out, 2);
    applyStimulus(-16'sd3);
    checkOutput("round -1.5", bus.y_out, -1);
    writeCoef(3'd6, ONE);
    applyStimulus(16'sd1000);
    checkOutput("addr6 ignored", bus.y_out, 500);

    // a1 = -0.5 feedback, impulse.
    writeCoef(3'd0, ONE);
    bus.clear = 1'b1;
    writeCoef(3'd3, NEG_HALF);
    applyStimulus(16'sd1000);
    checkOutput("a1 imp0", bus.y_out, 1000);
    applyStimulus(16'sd0);
    checkOutput("a1 imp1", bus.y_out, -500);
    applyStimulus(16'sd0);
    checkOutput("a1 imp2", bus.y_out, 250);

    // a2 = +0.5 feedback, impulse.
    writeCoef(3'd3, '0);
    bus.clear = 1'b1;
    writeCoef(3'd4, HALF);
    applyStimulus(16'sd1000);
    checkOutput("a2 imp0", bus.y_out, 1000);
    applyStimulus(16'sd0);
    checkOutput("a2 imp1", bus.y_out, 0);
    applyStimulus(16'sd0);
    checkOutput("a2 imp2", bus.y_out, 500);
    applyStimulus(16'sd0);
    checkOutput("a2 imp3", bus.y_out, 0);
    writeCoef(3'd4, '0);

    // Trigger and holdoff with identity filter.
    bus.clear = 1'b1;
    tick();
    applyStimulus(-16'sd20);
    checkOutput("arm sample trig", bus.trigger, 0);
    applyStimulus(-16'sd20);
    checkOutput("armed trig", bus.trigger, 0);
    applyStimulus(16'sd5);
    checkOutput("cross trig", bus.trigger, 1);
    checkOutput("cross y", bus.y_out, 5);
    checkOutput("cross count", bus.trig_count, 1);
    applyStimulus(-16'sd20);
    checkOutput("trig pulse end", bus.trigger, 0);
    applyStimulus(16'sd5);
    checkOutput("hold no trig", bus.trigger, 0);
    for (int i = 0; i < 61; i++) applyStimulus(16'sd0);
    applyStimulus(-16'sd20);
    applyStimulus(16'sd5);
    checkOutput("hold last ignored", bus.trigger, 0);
    checkOutput("hold count", bus.trig_count, 1);
    applyStimulus(-16'sd20);
    applyStimulus(16'sd5);
    checkOutput("rearm trig", bus.trigger, 1);
    checkOutput("rearm count", bus.trig_count, 2);

    // Window expiry after 128 samples, then a fresh trigger.
    bus.clear = 1'b1;
    tick();
    applyStimulus(-16'sd20);
    for (int i = 0; i < 128; i++) applyStimulus(-16'sd1);
    applyStimulus(16'sd1);
    checkOutput("window expired", bus.trigger, 0);
    checkOutput("window count", bus.trig_count, 0);
    applyStimulus(-16'sd20);
    applyStimulus(16'sd1);
    checkOutput("after window trig", bus.trigger, 1);
    checkOutput("after window count", bus.trig_count, 1);

    // Crossover on the window-expiry sample still triggers.
    bus.clear = 1'b1;
    tick();
    applyStimulus(-16'sd20);
    for (int i = 0; i < 127; i++) applyStimulus(-16'sd1);
    applyStimulus(16'sd1);
    checkOutput("cross wins expiry", bus.trigger, 1);

    // Bypass: registered passthrough, history frozen, FSM still runs.
    writeCoef(3'd0, '0);
    bus.clear = 1'b1;
    writeCoef(3'd2, ONE);
    applyStimulus(16'sd100);
    checkOutput("b2 delay 0", bus.y_out, 0);
    applyStimulus(16'sd200);
    checkOutput("b2 delay 1", bus.y_out, 0);
    bus.bypass = 1'b1;
    applyStimulus(-16'sd20);
    checkOutput("bypass valid", bus.out_valid, 1);
    checkOutput("bypass y", bus.y_out, -20);
    applyStimulus(16'sd3);
    checkOutput("bypass trig", bus.trigger, 1);
    checkOutput("bypass count", bus.trig_count, 1);
    bus.bypass = 1'b0;
    applyStimulus(16'sd300);
    checkOutput("history frozen", bus.y_out, 100);

    // Async reset in mid-cycle while outputs are active.
    bus.bypass = 1'b1;
    bus.clear  = 1'b1;
    tick();
    applyStimulus(-16'sd20);
    applyStimulus(16'sd3);
    checkOutput("pre-reset trig", bus.trigger, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async y_out", bus.y_out, 0);
    checkOutput("async out_valid", bus.out_valid, 0);
    checkOutput("async trigger", bus.trigger, 0);
    checkOutput("async trig_count", bus.trig_count, 0);
    checkOutput("async sat_flag", bus.sat_flag, 0);
    #4 reset_n = 1'b1;
    bus.bypass = 1'b0;
    @(negedge clk);
    applyStimulus(16'sd1000);
    checkOutput("defaults s1", bus.y_out, 973);
    applyStimulus(16'sd1000);
    checkOutput("defaults s2", bus.y_out, 2282);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
